// File: rtl/plot_arbiter_pkg.sv
// Shared drawing definitions for the plot arbiter: colours, screen bounds and FSM states.
// The CLEAR state exists only when PLOT_ARB_CLEAR_EN is defined.
package plot_arbiter_pkg;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  localparam int unsigned DEF_SIZE  = 4;
  localparam int unsigned DEF_X_MAX = 159;
  localparam int unsigned DEF_Y_MAX = 119;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef PLOT_ARB_CLEAR_EN
    ST_CLEAR = 2'd2,
`endif
    ST_SCAN  = 2'd1
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plot_arbiter_square_scan.sv
// square_scan: W x H raster counter, x fastest, wrapping back to (0,0) after the last cell.
// Exposes the next position so the owner can register pixel outputs with one cycle latency.
module square_scan
  import plot_arbiter_pkg::*;
#(
  parameter  int unsigned W  = DEF_SIZE,
  parameter  int unsigned H  = DEF_SIZE,
  localparam int unsigned XW = cnt_w(W),
  localparam int unsigned YW = cnt_w(H)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start_i,
  input  logic          step_i,
  output logic [XW-1:0] px_nxt_o,
  output logic [YW-1:0] py_nxt_o,
  output logic          last_o
);

  logic [XW-1:0] px_q, px_d;
  logic [YW-1:0] py_q, py_d;

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (start_i) begin
      px_d = '0;
      py_d = '0;
    end else if (step_i) begin
      if (px_q == XW'(W - 1)) begin
        px_d = '0;
        py_d = (py_q == YW'(H - 1)) ? '0 : py_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  assign px_nxt_o = px_d;
  assign py_nxt_o = py_d;
  assign last_o   = (px_q == XW'(W - 1)) && (py_q == YW'(H - 1));

endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin share of the VGA plot port between two square requesters.
// Optional full-screen black clear enabled by defining PLOT_ARB_CLEAR_EN.
module plot_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter int unsigned SIZE  = DEF_SIZE,
  parameter int unsigned X_MAX = DEF_X_MAX,
  parameter int unsigned Y_MAX = DEF_Y_MAX
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] a_x,
  input  logic [6:0] a_y,
  input  logic [2:0] a_colour,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [7:0] b_x,
  input  logic [6:0] b_y,
  input  logic [2:0] b_colour,
`ifdef PLOT_ARB_CLEAR_EN
  input  logic       clear_req,
`endif
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       a_done,
  output logic       b_done,
  output logic       busy
);

  localparam int unsigned PW = cnt_w(SIZE);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       last_b_q, last_b_d;
  logic [7:0] base_x_q, base_x_d;
  logic [6:0] base_y_q, base_y_d;
  logic [2:0] base_c_q, base_c_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] c_q, c_d;
  logic       plot_q, plot_d;
  logic       adone_q, adone_d;
  logic       bdone_q, bdone_d;

  logic          grant_a, grant_b;
  logic          sq_start, sq_step, sq_last;
  logic [PW-1:0] sq_px_nxt, sq_py_nxt;
  logic [8:0]    sum_x;
  logic [7:0]    sum_y;

  square_scan #(.W(SIZE), .H(SIZE)) u_sq (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (sq_start),
    .step_i   (sq_step),
    .px_nxt_o (sq_px_nxt),
    .py_nxt_o (sq_py_nxt),
    .last_o   (sq_last)
  );

`ifdef PLOT_ARB_CLEAR_EN
  localparam int unsigned CXW = cnt_w(X_MAX + 1);
  localparam int unsigned CYW = cnt_w(Y_MAX + 1);

  logic           pend_q, pend_d;
  logic           clr_start, clr_step, clr_last;
  logic [CXW-1:0] clr_px_nxt;
  logic [CYW-1:0] clr_py_nxt;

  square_scan #(.W(X_MAX + 1), .H(Y_MAX + 1)) u_clr (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (clr_start),
    .step_i   (clr_step),
    .px_nxt_o (clr_px_nxt),
    .py_nxt_o (clr_py_nxt),
    .last_o   (clr_last)
  );
`endif

  // A tie goes to whichever side was not granted last.
  assign grant_a = a_valid && (!b_valid || last_b_q);
  assign grant_b = b_valid && !grant_a;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_b_d = last_b_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    base_c_d = base_c_q;
    x_d      = '0;
    y_d      = '0;
    c_d      = BLACK;
    plot_d   = 1'b0;
    adone_d  = 1'b0;
    bdone_d  = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    sq_start = 1'b0;
    sq_step  = 1'b0;
    sum_x    = '0;
    sum_y    = '0;
`ifdef PLOT_ARB_CLEAR_EN
    clr_start = 1'b0;
    clr_step  = 1'b0;
    pend_d    = pend_q || (clear_req && (state_q != ST_IDLE));
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef PLOT_ARB_CLEAR_EN
        if (clear_req || pend_q) begin
          state_d   = ST_CLEAR;
          clr_start = 1'b1;
          pend_d    = 1'b0;
          plot_d    = 1'b1;
        end else
`endif
        if (grant_a || grant_b) begin
          a_ready  = grant_a;
          b_ready  = grant_b;
          state_d  = ST_SCAN;
          sq_start = 1'b1;
          last_b_d = grant_b;
          owner_d  = grant_b ? OWN_B : OWN_A;
          base_x_d = grant_b ? b_x : a_x;
          base_y_d = grant_b ? b_y : a_y;
          base_c_d = grant_b ? b_colour : a_colour;
          // First pixel is the corner itself, registered on the accept edge.
          sum_x    = {1'b0, base_x_d};
          sum_y    = {1'b0, base_y_d};
          x_d      = sum_x[7:0];
          y_d      = sum_y[6:0];
          c_d      = base_c_d;
          plot_d   = (sum_x <= 9'(X_MAX)) && (sum_y <= 8'(Y_MAX));
        end
      end

      ST_SCAN: begin
        sq_step = 1'b1;
        if (sq_last) begin
          state_d = ST_IDLE;
        end else begin
          sum_x   = {1'b0, base_x_q} + 9'(sq_px_nxt);
          sum_y   = {1'b0, base_y_q} + 8'(sq_py_nxt);
          x_d     = sum_x[7:0];
          y_d     = sum_y[6:0];
          c_d     = base_c_q;
          plot_d  = (sum_x <= 9'(X_MAX)) && (sum_y <= 8'(Y_MAX));
          adone_d = (owner_q == OWN_A) && (sq_px_nxt == PW'(SIZE - 1))
                    && (sq_py_nxt == PW'(SIZE - 1));
          bdone_d = (owner_q == OWN_B) && (sq_px_nxt == PW'(SIZE - 1))
                    && (sq_py_nxt == PW'(SIZE - 1));
        end
      end

`ifdef PLOT_ARB_CLEAR_EN
      ST_CLEAR: begin
        clr_step = 1'b1;
        if (clr_last) begin
          state_d = ST_IDLE;
        end else begin
          x_d    = 8'(clr_px_nxt);
          y_d    = 7'(clr_py_nxt);
          plot_d = 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_A;
      last_b_q <= 1'b1;
      base_x_q <= '0;
      base_y_q <= '0;
      base_c_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      c_q      <= '0;
      plot_q   <= 1'b0;
      adone_q  <= 1'b0;
      bdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_b_q <= last_b_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      base_c_q <= base_c_d;
      x_q      <= x_d;
      y_q      <= y_d;
      c_q      <= c_d;
      plot_q   <= plot_d;
      adone_q  <= adone_d;
      bdone_q  <= bdone_d;
    end
  end

`ifdef PLOT_ARB_CLEAR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pend_q <= 1'b0;
    else         pend_q <= pend_d;
  end
`endif

  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = c_q;
  assign vga_plot   = plot_q;
  assign a_done     = adone_q;
  assign b_done     = bdone_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter (default build, clear feature off).
// Expected pixels come from a plain arithmetic model of the square raster and round-robin rule.
module tb_plot_arbiter;

  localparam int S    = 4;
  localparam int NPIX = S * S;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, b_ready;
  logic [7:0] a_x = '0, b_x = '0;
  logic [6:0] a_y = '0, b_y = '0;
  logic [2:0] a_colour = '0, b_colour = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, a_done, b_done, busy;

  int tests = 0;
  int failed = 0;
  bit model_last_a;

  logic [7:0] ox[NPIX];
  logic [6:0] oy[NPIX];
  logic [2:0] oc[NPIX];
  logic       op[NPIX], oa[NPIX], ob[NPIX], obusy[NPIX];

  always #5 clk = ~clk;

  plot_arbiter #(.SIZE(S), .X_MAX(159), .Y_MAX(119)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_x        (a_x),
    .a_y        (a_y),
    .a_colour   (a_colour),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_x        (b_x),
    .b_y        (b_y),
    .b_colour   (b_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .a_done     (a_done),
    .b_done     (b_done),
    .busy       (busy)
  );

  // Pixel k of a square at (bx,by): x fastest, visible only inside the 160x120 screen.
  function automatic void model_pix(input int bx, input int by, input int k,
                                    output int ex, output int ey, output bit ep);
    ex = bx + k % S;
    ey = by + k / S;
    ep = (ex <= 159) && (ey <= 119);
  endfunction

  task automatic capture();
    for (int i = 0; i < NPIX; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      ox[i] = vga_x; oy[i] = vga_y; oc[i] = vga_colour;
      op[i] = vga_plot; oa[i] = a_done; ob[i] = b_done; obusy[i] = busy;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    model_last_a = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({vga_x, vga_y, vga_colour, vga_plot, a_done, b_done, busy, a_ready, b_ready} !== '0) begin
      failed++;
      $display("FAIL reset: got x=%0d y=%0d c=%0d plot=%b ad=%b bd=%b busy=%b ar=%b br=%b, want all 0",
               vga_x, vga_y, vga_colour, vga_plot, a_done, b_done, busy, a_ready, b_ready);
    end
  endtask

  task automatic test_single_a();
    int ex, ey; bit ep;
    a_x = 8'd10; a_y = 7'd53; a_colour = 3'b100; a_valid = 1'b1;
    #1;
    tests++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      failed++; $display("FAIL single_ready: got ar=%b br=%b, want ar=1 br=0", a_ready, b_ready);
    end
    @(posedge clk); #1; a_valid = 1'b0; model_last_a = 1'b1;
    capture();
    for (int k = 0; k < NPIX; k++) begin
      model_pix(10, 53, k, ex, ey, ep);
      tests++;
      if (op[k] !== ep || (ep && (ox[k] !== 8'(ex) || oy[k] !== 7'(ey) || oc[k] !== 3'b100))
          || oa[k] !== (k == NPIX - 1) || ob[k] !== 1'b0 || obusy[k] !== 1'b1) begin
        failed++;
        $display("FAIL single_pix%0d: got x=%0d y=%0d c=%0d plot=%b ad=%b bd=%b busy=%b, want x=%0d y=%0d c=4 plot=%b ad=%b",
                 k, ox[k], oy[k], oc[k], op[k], oa[k], ob[k], obusy[k], ex, ey, ep, k == NPIX - 1);
      end
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || vga_plot !== 1'b0 || a_done !== 1'b0) begin
      failed++; $display("FAIL single_idle: got busy=%b plot=%b ad=%b, want 0 0 0", busy, vga_plot, a_done);
    end
  endtask

  task automatic test_round_robin();
    int ex, ey, bx, by; bit ep, win_a;
    logic [2:0] col;
    do_reset();
    a_x = 8'd20; a_y = 7'd30; a_colour = 3'b010;
    b_x = 8'd100; b_y = 7'd60; b_colour = 3'b001;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      #1;
      win_a = !model_last_a;
      tests++;
      if (a_ready !== win_a || b_ready !== !win_a) begin
        failed++; $display("FAIL rr_grant%0d: got ar=%b br=%b, want ar=%b br=%b", r, a_ready, b_ready, win_a, !win_a);
      end
      @(posedge clk); #1;
      model_last_a = win_a;
      bx = win_a ? 20 : 100; by = win_a ? 30 : 60; col = win_a ? 3'b010 : 3'b001;
      capture();
      for (int k = 0; k < NPIX; k++) begin
        model_pix(bx, by, k, ex, ey, ep);
        tests++;
        if (op[k] !== ep || (ep && (ox[k] !== 8'(ex) || oy[k] !== 7'(ey) || oc[k] !== col))
            || oa[k] !== (win_a && k == NPIX - 1) || ob[k] !== (!win_a && k == NPIX - 1)) begin
          failed++;
          $display("FAIL rr%0d_pix%0d: got x=%0d y=%0d c=%0d plot=%b ad=%b bd=%b, want x=%0d y=%0d c=%0d plot=%b owner_a=%b",
                   r, k, ox[k], oy[k], oc[k], op[k], oa[k], ob[k], ex, ey, col, ep, win_a);
        end
      end
      @(posedge clk);
    end
    #1; a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_edge_clip();
    int ex, ey, nplot; bit ep, win_a;
    @(posedge clk); #1;
    b_x = 8'd158; b_y = 7'd118; b_colour = 3'b111; b_valid = 1'b1;
    #1;
    tests++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      failed++; $display("FAIL clip_ready: got ar=%b br=%b, want ar=0 br=1", a_ready, b_ready);
    end
    @(posedge clk); #1; b_valid = 1'b0; model_last_a = 1'b0;
    capture();
    nplot = 0;
    for (int k = 0; k < NPIX; k++) begin
      model_pix(158, 118, k, ex, ey, ep);
      win_a = 1'b0;
      if (op[k] === 1'b1) nplot++;
      tests++;
      if (op[k] !== ep || (ep && (ox[k] !== 8'(ex) || oy[k] !== 7'(ey) || oc[k] !== 3'b111))
          || ob[k] !== (!win_a && k == NPIX - 1) || oa[k] !== 1'b0) begin
        failed++;
        $display("FAIL clip_pix%0d: got x=%0d y=%0d plot=%b bd=%b, want x=%0d y=%0d plot=%b",
                 k, ox[k], oy[k], op[k], ob[k], ex, ey, ep);
      end
    end
    tests++;
    if (nplot !== 4) begin
      failed++; $display("FAIL clip_count: got %0d plotted pixels, want 4", nplot);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_scan();
    int ex, ey; bit ep;
    a_x = 8'd5; a_y = 7'd5; a_colour = 3'b011; a_valid = 1'b1;
    @(posedge clk); #1; a_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    tests++;
    if (vga_plot !== 1'b0 || busy !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0 || a_done !== 1'b0) begin
      failed++; $display("FAIL rst_async: got plot=%b busy=%b x=%0d y=%0d ad=%b, want all 0", vga_plot, busy, vga_x, vga_y, a_done);
    end
    a_x = 8'd40; a_y = 7'd80; a_colour = 3'b101; a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (a_done !== 1'b0 || b_done !== 1'b0 || vga_plot !== 1'b0) begin
        failed++; $display("FAIL rst_hold%0d: got ad=%b bd=%b plot=%b, want 0 0 0", i, a_done, b_done, vga_plot);
      end
    end
    resetn = 1'b1; model_last_a = 1'b0;
    #1;
    tests++;
    if (a_ready !== 1'b1) begin
      failed++; $display("FAIL rst_first_accept: got ar=%b, want 1", a_ready);
    end
    @(posedge clk); #1; a_valid = 1'b0; model_last_a = 1'b1;
    capture();
    for (int k = 0; k < NPIX; k++) begin
      model_pix(40, 80, k, ex, ey, ep);
      tests++;
      if (op[k] !== ep || (ep && (ox[k] !== 8'(ex) || oy[k] !== 7'(ey) || oc[k] !== 3'b101))
          || oa[k] !== (k == NPIX - 1)) begin
        failed++;
        $display("FAIL rst_pix%0d: got x=%0d y=%0d c=%0d plot=%b ad=%b, want x=%0d y=%0d c=5 plot=%b",
                 k, ox[k], oy[k], oc[k], op[k], oa[k], ex, ey, ep);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_late_a();
    int ex, ey, bx, by; bit ep, own_a;
    logic [2:0] col;
    b_x = 8'd30; b_y = 7'd40; b_colour = 3'b011; b_valid = 1'b1;
    #1;
    tests++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      failed++; $display("FAIL late_b_ready: got ar=%b br=%b, want ar=0 br=1", a_ready, b_ready);
    end
    @(posedge clk); #1; b_valid = 1'b0; model_last_a = 1'b0;
    a_x = 8'd70; a_y = 7'd20; a_colour = 3'b110; a_valid = 1'b1;
    for (int sq = 0; sq < 2; sq++) begin
      own_a = (sq == 1);
      bx = own_a ? 70 : 30; by = own_a ? 20 : 40; col = own_a ? 3'b110 : 3'b011;
      #1;
      tests++;
      if (a_ready !== 1'b0) begin
        failed++; $display("FAIL late_ready_busy%0d: got ar=%b, want 0", sq, a_ready);
      end
      capture();
      for (int k = 0; k < NPIX; k++) begin
        model_pix(bx, by, k, ex, ey, ep);
        tests++;
        if (op[k] !== ep || (ep && (ox[k] !== 8'(ex) || oy[k] !== 7'(ey) || oc[k] !== col))
            || oa[k] !== (own_a && k == NPIX - 1) || ob[k] !== (!own_a && k == NPIX - 1)) begin
          failed++;
          $display("FAIL late%0d_pix%0d: got x=%0d y=%0d c=%0d plot=%b ad=%b bd=%b, want x=%0d y=%0d c=%0d plot=%b",
                   sq, k, ox[k], oy[k], oc[k], op[k], oa[k], ob[k], ex, ey, col, ep);
        end
      end
      @(posedge clk); #1;
      if (sq == 0) begin
        tests++;
        if (a_ready !== 1'b1 || busy !== 1'b0) begin
          failed++; $display("FAIL late_a_first_idle: got ar=%b busy=%b, want ar=1 busy=0", a_ready, busy);
        end
        @(posedge clk); #1; a_valid = 1'b0; model_last_a = 1'b1;
      end
    end
  endtask

  task automatic test_random();
    int ex, ey, bx, by, ax_r, ay_r, bx_r, by_r; bit ep, av, bv, win_a;
    logic [2:0] ac_r, bc_r, col;
    for (int r = 0; r < 12; r++) begin
      av = 1'($urandom_range(0, 1));
      bv = av ? 1'($urandom_range(0, 1)) : 1'b1;
      ax_r = $urandom_range(0, 255); ay_r = $urandom_range(0, 127);
      bx_r = $urandom_range(0, 255); by_r = $urandom_range(0, 127);
      ac_r = 3'($urandom_range(0, 7)); bc_r = 3'($urandom_range(0, 7));
      a_x = 8'(ax_r); a_y = 7'(ay_r); a_colour = ac_r; a_valid = av;
      b_x = 8'(bx_r); b_y = 7'(by_r); b_colour = bc_r; b_valid = bv;
      win_a = av && (!bv || !model_last_a);
      #1;
      tests++;
      if (a_ready !== win_a || b_ready !== !win_a) begin
        failed++; $display("FAIL rand%0d_grant: got ar=%b br=%b, want ar=%b br=%b", r, a_ready, b_ready, win_a, !win_a);
      end
      @(posedge clk); #1; a_valid = 1'b0; b_valid = 1'b0;
      model_last_a = win_a;
      bx = win_a ? ax_r : bx_r; by = win_a ? ay_r : by_r; col = win_a ? ac_r : bc_r;
      capture();
      for (int k = 0; k < NPIX; k++) begin
        model_pix(bx, by, k, ex, ey, ep);
        tests++;
        if (op[k] !== ep || (ep && (ox[k] !== 8'(ex) || oy[k] !== 7'(ey) || oc[k] !== col))
            || oa[k] !== (win_a && k == NPIX - 1) || ob[k] !== (!win_a && k == NPIX - 1)
            || obusy[k] !== 1'b1) begin
          failed++;
          $display("FAIL rand%0d_pix%0d: got x=%0d y=%0d c=%0d plot=%b ad=%b bd=%b busy=%b, want x=%0d y=%0d c=%0d plot=%b owner_a=%b",
                   r, k, ox[k], oy[k], oc[k], op[k], oa[k], ob[k], obusy[k], ex, ey, col, ep, win_a);
        end
      end
      @(posedge clk); #1;
      tests++;
      if (busy !== 1'b0 || vga_plot !== 1'b0) begin
        failed++; $display("FAIL rand%0d_idle: got busy=%b plot=%b, want 0 0", r, busy, vga_plot);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_edge_clip();
    test_reset_mid_scan();
    test_late_a();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
